// File: rtl/cgra_conf_dist_if.sv
// cgra_conf_dist_if: burst control, word stream and configuration tap bus of the distributor
interface cgra_conf_dist_if #(
    parameter int CONF_WIDTH = 64,
    parameter int NUM_TAPS   = 6,
    parameter int CNT_WIDTH  = 16
);
    logic                           start;
    logic [CNT_WIDTH-1:0]           num_words;
    logic                           flush;
    logic                           s_valid;
    logic                           s_ready;
    logic [CONF_WIDTH-1:0]          s_data;
    logic [NUM_TAPS*CONF_WIDTH-1:0] conf_tap;
    logic                           busy;
    logic                           done;
    logic [CNT_WIDTH-1:0]           words_left;

    modport master (
        output start, num_words, flush, s_valid, s_data,
        input  s_ready, conf_tap, busy, done, words_left
    );
    modport slave (
        input  start, num_words, flush, s_valid, s_data,
        output s_ready, conf_tap, busy, done, words_left
    );
endinterface

// File: rtl/cgra_conf_dist.sv
// cgra_conf_dist: counted-burst loader feeding a free-running configuration shift chain
module cgra_conf_dist #(
    parameter int CONF_WIDTH = 64,
    parameter int NUM_TAPS   = 6,
    parameter int CNT_WIDTH  = 16
) (
    input logic              clk_i,
    input logic              rst_ni,
    cgra_conf_dist_if.slave  bus
);
    localparam int DW = NUM_TAPS > 1 ? $clog2(NUM_TAPS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, ZDONE} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  left_q, left_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic [CONF_WIDTH-1:0] tap_q [NUM_TAPS];
    logic                  accept;

    assign bus.s_ready    = state_q == LOAD && !bus.flush;
    assign accept         = bus.s_ready && bus.s_valid;
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = state_q == ZDONE || (state_q == DRAIN && drain_q == '0);
    assign bus.words_left = left_q;

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        drain_d = drain_q;
        case (state_q)
            IDLE:  if (bus.start) begin
                       state_d = bus.num_words != '0 ? LOAD : ZDONE;
                       left_d  = bus.num_words;
                   end
            LOAD:  if (accept) begin
                       left_d = left_q - 1'b1;
                       if (left_q == CNT_WIDTH'(1)) begin
                           state_d = DRAIN;
                           drain_d = DW'(NUM_TAPS - 1);
                       end
                   end
            DRAIN: begin
                       state_d = drain_q == '0 ? IDLE : DRAIN;
                       drain_d = drain_q == '0 ? drain_q : drain_q - 1'b1;
                   end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d = IDLE;
            left_d  = '0;
            drain_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            left_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            drain_q <= drain_d;
        end
    end

    // no enable: idle and bubble cycles push all-zero NOP words down the chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_TAPS; k++) tap_q[k] <= '0;
        end else begin
            tap_q[0] <= accept ? bus.s_data : '0;
            for (int k = 1; k < NUM_TAPS; k++) tap_q[k] <= bus.flush ? '0 : tap_q[k-1];
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_tap
        assign bus.conf_tap[g*CONF_WIDTH +: CONF_WIDTH] = tap_q[g];
    end
endmodule

// File: tb/tb_cgra_conf_dist.sv
// tb_cgra_conf_dist: directed test-plan bursts plus random traffic against a cycle-history model
module tb_cgra_conf_dist;
    localparam int CW = 64;
    localparam int NT = 6;
    localparam int NW = 16;
    localparam int TW = CW * NT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cgra_conf_dist_if #(.CONF_WIDTH(CW), .NUM_TAPS(NT), .CNT_WIDTH(NW)) bus ();

    cgra_conf_dist #(.CONF_WIDTH(CW), .NUM_TAPS(NT), .CNT_WIDTH(NW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int vecs = 0;
    int errs = 0;
    logic [CW-1:0] hist [$];
    int phase = 0;
    int left = 0;
    int done_at = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] exp_taps();
        logic [TW-1:0] v;
        v = '0;
        for (int k = 0; k < NT; k++)
            if (k < hist.size()) v[k*CW +: CW] = hist[k];
        return v;
    endfunction

    task automatic check_outs(input logic fl);
        logic rdy, dn;
        rdy = phase == 1 && !fl;
        dn  = phase == 3 || (phase == 2 && cyc == done_at);
        chk("s_ready", TW'(bus.s_ready), TW'(rdy));
        chk("busy", TW'(bus.busy), TW'(phase != 0));
        chk("done", TW'(bus.done), TW'(dn));
        chk("words_left", TW'(bus.words_left), TW'(NW'(left)));
        chk("conf_tap", bus.conf_tap, exp_taps());
    endtask

    task automatic step(input logic st, input logic [NW-1:0] nw, input logic fl,
                        input logic v, input logic [CW-1:0] d);
        logic acc;
        bus.start = st; bus.num_words = nw; bus.flush = fl; bus.s_valid = v; bus.s_data = d;
        #3;
        check_outs(fl);
        acc = phase == 1 && !fl && v;
        @(posedge clk);
        #1;
        if (fl) begin
            hist.delete();
            phase = 0;
            left = 0;
        end else begin
            hist.push_front(acc ? d : '0);
            if (hist.size() > NT) void'(hist.pop_back());
            case (phase)
                0: if (st) begin
                       if (nw != 0) begin phase = 1; left = int'(nw); end
                       else phase = 3;
                   end
                1: if (acc) begin
                       left--;
                       if (left == 0) begin phase = 2; done_at = cyc + NT; end
                   end
                2: if (cyc == done_at) phase = 0;
                default: phase = 0;
            endcase
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom});
    endtask

    task automatic async_rst();
        rst_n = 1'b0;
        #1;
        chk("rst_taps", bus.conf_tap, '0);
        chk("rst_busy", TW'(bus.busy), '0);
        chk("rst_ready", TW'(bus.s_ready), '0);
        chk("rst_done", TW'(bus.done), '0);
        chk("rst_left", TW'(bus.words_left), '0);
        hist.delete();
        phase = 0;
        left = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.start = 1'b0; bus.num_words = '0; bus.flush = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
        @(posedge clk);
        #1;
        async_rst();
        idle(10);
        step(1'b1, 16'd3, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 64'hA1);
        step(1'b0, '0, 1'b0, 1'b1, 64'hA2);
        step(1'b0, '0, 1'b0, 1'b1, 64'hA3);
        repeat (8) step(1'b0, '0, 1'b0, 1'b0, '0);
        step(1'b1, 16'd2, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 64'hB1);
        step(1'b0, '0, 1'b0, 1'b0, 64'hDEAD);
        step(1'b0, '0, 1'b0, 1'b1, 64'hB2);
        repeat (8) step(1'b0, '0, 1'b0, 1'b0, '0);
        step(1'b1, 16'd0, 1'b0, 1'b0, '0);
        idle(3);
        step(1'b1, 16'd4, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 64'hC1);
        step(1'b0, '0, 1'b1, 1'b1, 64'hC2);
        idle(3);
        step(1'b1, 16'd1, 1'b1, 1'b0, '0);
        step(1'b1, 16'd2, 1'b0, 1'b0, '0);
        step(1'b1, 16'd7, 1'b0, 1'b1, 64'hD1);
        step(1'b1, 16'd7, 1'b0, 1'b1, 64'hD2);
        repeat (8) step(1'b1, 16'd5, 1'b0, 1'b1, 64'hEE);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        idle(2);
        step(1'b1, 16'd1, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 64'hF1);
        step(1'b0, '0, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b0, '0);
        async_rst();
        idle(4);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) async_rst();
            step(1'($urandom_range(0, 7) == 0), NW'($urandom_range(0, 5)),
                 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), {$urandom, $urandom});
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
